dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 16384, memory size in 32-bit words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between accept and response (0..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 req_valid  input  1  CPU presents an access.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-008 req_wdata  input  32  write data.
REQ-009 req_be  input  4  byte enables; be[i] selects bits [8i+7:8i].
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_rdata  output  32  read data; 0 for write responses.
REQ-013 rsp_ready  input  1  CPU consumes the response.
REQ-014 done  output  1  sticky: program signalled completion.
REQ-015 cycle_count  output  32  cycles since end of clear, frozen at done.

Function
REQ-016 FSM states: CLEAR, IDLE, WAIT, RESP.
REQ-017 CLEAR: writes 0 to one word per cycle, index 0..DEPTH-1; req_ready=0; transitions to IDLE after word DEPTH-1.
REQ-018 IDLE: req_ready=1; req_valid=1 accepts and latches we/addr/wdata/be; goes to WAIT if WAIT_CYCLES>0, else RESP.
REQ-019 WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; goes to RESP when it reaches 0; req_ready=0.
REQ-020 A write commits on the WAIT->RESP or IDLE->RESP transition edge, updating only enabled bytes.
REQ-021 A read samples the word on that same edge; rsp_rdata holds the value until the response is consumed.
REQ-022 Accept-to-rsp_valid latency is exactly WAIT_CYCLES+1 cycles.
REQ-023 RESP: rsp_valid=1 and rsp_rdata stable until rsp_ready=1; that cycle goes to IDLE; req_ready=0 in RESP (no back-to-back accept).
REQ-024 req_addr[1:0] and bits above the word index are ignored; addresses wrap modulo DEPTH words.
REQ-025 req_be=4'b0000 write: no memory change; still completes handshake.
REQ-026 cycle_count increments every cycle from the first IDLE cycle until done; saturates at 32'hFFFF_FFFF.
REQ-027 done sets the cycle after a committed write leaves word 0 equal to 32'h0000_0001; cycle_count stops in the same cycle done rises.
REQ-028 Writes to word 0 after done do not clear done.

Reset
REQ-029 rst=0 at a rising edge forces state CLEAR, clear index 0, wait counter 0, any in-flight access dropped (no commit).
REQ-030 Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, done=0, cycle_count=0.
REQ-031 Memory contents are zeroed only by the CLEAR sweep, never by a combinational or bulk reset.

Structure
REQ-032 Shared package holds the FSM state encoding (2 bits) and the completion constant 32'h0000_0001.
REQ-033 One sub-module, dmem_array: single-port DEPTH x 32 synchronous RAM with byte-enable write; FSM and monitor stay in dmem_responder.

Verification
REQ-034 DEPTH=16, reset released -> req_ready=0 for 16 cycles, then 1; every word reads back 0.
REQ-035 WAIT_CYCLES=2, write addr 0x8, data 0xDEADBEEF, be=1111, rsp_ready=1 -> rsp_valid 3 cycles after accept; then read 0x8 returns 0xDEADBEEF.
REQ-036 Write 0xFFFFFFFF to 0x4, then write 0x00000000 be=0101 -> read 0x4 returns 0xFF00FF00.
REQ-037 Read 0x40 with DEPTH=16 after write 0x11223344 to 0x0 via be=1111 -> returns 0x11223344 (wrap); rsp_ready held 0 for 5 cycles -> rsp_valid and data stable throughout.
REQ-038 Write 0x1 to address 0x0 at cycle N -> done=1 next cycle, cycle_count frozen; later write 0x0 to 0x0 -> done stays 1.
REQ-039 rst asserted in WAIT of a write to 0xC -> after clear, read 0xC returns 0, rsp_valid=0 during reset.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Value the program writes to word 0 to signal completion.
  localparam logic [31:0] DONE_VALUE = 32'h0000_0001;

  // Byte-lane merge: lanes with be[i]=1 take new_word, others keep old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory request/response bus.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte-enable write; no reset on contents.
module dmem_array #(
  parameter int DEPTH = 16384,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write or registered read; rdata holds while the port is idle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears the RAM after reset, then serves one CPU
// access at a time with a fixed number of wait states, and watches word 0
// for the program's completion marker.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping zeros into the RAM, one word per cycle
// ST_IDLE  | ready to accept a request
// ST_WAIT  | wait states counting down; access commits on the last one
// ST_RESP  | response presented until the CPU consumes it
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_responder_if.slave       bus,
  output logic                  done,
  output logic [31:0]           cycle_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state;
  logic [AW-1:0] clear_idx;
  logic [3:0]    wait_cnt;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic [31:0]   word0_q;

  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          commit;
  logic          done_set;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;

  logic          unused_addr;
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  // With zero wait states the access commits on the accept edge itself, so
  // it must come straight from the bus rather than from the latched copy.
  assign acc_we    = (WAIT_CYCLES == 0) ? bus.req_we            : lat_we;
  assign acc_idx   = (WAIT_CYCLES == 0) ? bus.req_addr[AW+1:2]  : lat_idx;
  assign acc_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata         : lat_wdata;
  assign acc_be    = (WAIT_CYCLES == 0) ? bus.req_be            : lat_be;

  assign commit = ((state == ST_WAIT) && (wait_cnt == 4'd0)) ||
                  ((state == ST_IDLE) && bus.req_valid && (WAIT_CYCLES == 0));

  assign done_set = commit && acc_we && (acc_idx == '0) &&
                    (be_merge(word0_q, acc_wdata, acc_be) == DONE_VALUE);

  // RAM port steering: the clear sweep owns the port in ST_CLEAR; reset
  // gates the enable so an in-flight access is dropped.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = acc_idx;
    ram_wdata = acc_wdata;
    ram_be    = acc_be;
    if (state == ST_CLEAR) begin
      ram_en    = rst;
      ram_we    = 1'b1;
      ram_addr  = clear_idx;
      ram_wdata = '0;
      ram_be    = 4'hF;
    end else if (commit) begin
      ram_en = rst;
      ram_we = acc_we;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  // Main sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_CLEAR;
      clear_idx   <= '0;
      wait_cnt    <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      lat_we      <= 1'b0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == AW'(DEPTH - 1)) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_we      <= bus.req_we;
            lat_idx     <= bus.req_addr[AW+1:2];
            lat_wdata   <= bus.req_wdata;
            lat_be      <= bus.req_be;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Shadow of word 0 so completion can be judged on the commit edge
  // without a second RAM read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word0_q <= '0;
    end else if (ram_en && ram_we && (ram_addr == '0)) begin
      word0_q <= be_merge(word0_q, ram_wdata, ram_be);
    end
  end

  // Sticky completion flag and free-running cycle counter frozen at done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (done_set) done <= 1'b1;
      if ((state != ST_CLEAR) && !done && !done_set && (cycle_count != 32'hFFFF_FFFF))
        cycle_count <= cycle_count + 1'b1;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (rsp_valid_q && !lat_we) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder (DEPTH=16, WAIT_CYCLES=2).
module tb_dmem_responder;

  localparam int DEPTH = 16;
  localparam int WAITS = 2;

  logic        clk;
  logic        rst;
  logic        done;
  logic [31:0] cycle_count;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .done        (done),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int k0     = 0;
  int rsp_cyc;
  logic        rsp_done;
  logic [31:0] rsp_count;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int idx;
    idx = word_of(addr);
    for (int i = 0; i < 4; i++)
      if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    rst = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("clear_length", n, DEPTH);
    k0 = cyc;
    check("count_first_idle", cycle_count, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] rdata);
    int n;
    logic [31:0] exp;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $error("FAIL ready_timeout: observed %b expected 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, WAITS + 1);
    rsp_cyc   = cyc;
    rsp_done  = done;
    rsp_count = cycle_count;
    if (we) begin
      model_write(addr, wdata, be);
      exp = 32'd0;
    end else begin
      exp = model[word_of(addr)];
    end
    rdata = bus.rsp_rdata;
    check(we ? "wr_rdata" : "rd_rdata", rdata, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_rdata", bus.rsp_rdata, exp);
      check("hold_no_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_released", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] frozen;
    logic [31:0] a;
    logic        we;
    int n;

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    do_reset();

    // Every word reads back zero after the clear sweep.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 32'(i * 4), 32'd0, 4'hF, 0, rd);

    // Full-word write then read.
    access(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd);
    access(1'b0, 32'h8, 32'd0, 4'hF, 0, rd);

    // Partial byte-enable write.
    access(1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, 0, rd);
    access(1'b1, 32'h4, 32'h00000000, 4'b0101, 0, rd);
    access(1'b0, 32'h4, 32'd0, 4'hF, 0, rd);
    check("be_merge_word", rd, 32'hFF00FF00);

    // Address wrap and response back-pressure.
    access(1'b1, 32'h0, 32'h11223344, 4'hF, 0, rd);
    access(1'b0, 32'h40, 32'd0, 4'hF, 5, rd);
    check("wrap_word", rd, 32'h11223344);

    // Empty byte-enable write leaves memory untouched.
    access(1'b1, 32'h8, 32'h12345678, 4'h0, 0, rd);
    access(1'b0, 32'h8, 32'd0, 4'hF, 0, rd);

    @(negedge clk);
    check("count_running", cycle_count, 32'(cyc - k0));

    // Randomized traffic; word 0 only read so completion is not triggered.
    for (int t = 0; t < 80; t++) begin
      a  = $urandom;
      we = 1'($urandom_range(0, 1));
      if (word_of(a) == 0) we = 1'b0;
      access(we, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd);
    end
    check("done_before", {31'd0, done}, 32'd0);
    check("count_random", cycle_count, 32'(cyc - k0));

    // Completion marker in word 0.
    access(1'b1, 32'h0, 32'h00000001, 4'hF, 0, rd);
    check("done_at_rsp", {31'd0, rsp_done}, 32'd1);
    check("count_frozen_val", rsp_count, 32'(rsp_cyc - 1 - k0));
    frozen = rsp_count;
    repeat (5) @(negedge clk);
    check("count_frozen_later", cycle_count, frozen);
    access(1'b1, 32'h0, 32'h00000000, 4'hF, 0, rd);
    check("done_sticky", {31'd0, done}, 32'd1);
    check("count_still_frozen", cycle_count, frozen);

    // Reset during the wait states of a write drops the write.
    access(1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 0, rd);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'hC;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_be    = 4'hF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    do_reset();
    access(1'b0, 32'hC, 32'd0, 4'hF, 0, rd);
    check("after_rst_word3", rd, 32'd0);
    check("after_rst_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
